// File: rtl/nes6502_biu_if.sv
// Signal bundle between nes6502_biu, the execute unit and the memory port.
// slave = BIU side, master = execute unit / memory side.
interface nes6502_biu_if #(parameter int ADDR_W = 16);
   logic              req;
   logic [2:0]        op;
   logic [ADDR_W-1:0] addr_in;
   logic [7:0]        wdata;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_value;
   logic              busy;
   logic              done;
   logic [15:0]       rdata;
   logic [ADDR_W-1:0] pc;
   logic [7:0]        sp;
   logic [ADDR_W-1:0] address;
   logic [7:0]        data;
   logic [7:0]        out;
   logic              rd;
   logic              we;

   modport slave (input  req, op, addr_in, wdata, pc_load, pc_value, data,
                  output busy, done, rdata, pc, sp, address, out, rd, we);
   modport master (output req, op, addr_in, wdata, pc_load, pc_value, data,
                   input  busy, done, rdata, pc, sp, address, out, rd, we);
endinterface

// File: rtl/nes6502_biu.sv
// 6502 bus interface unit: owns PC/SP, sequences memory ops and the reset-vector boot.
// Optional NMOS_PAGE_WRAP_EN: READ16 high byte wraps within the page (NMOS JMP (ind) bug).
module nes6502_biu #(
   parameter int          ADDR_W       = 16,
   parameter logic [15:0] RESET_VECTOR = 16'hFFFC,
   parameter logic [7:0]  STACK_PAGE   = 8'h01,
   parameter logic [7:0]  SP_INIT      = 8'hFD
) (
   input logic          clock,
   input logic          reset,
   nes6502_biu_if.slave bif
);
   typedef enum logic [2:0] {BOOT, IDLE, ADDR_LO, DATA_LO, DATA_HI, WRITE, DONE} state_t;

   localparam logic [2:0] OP_FETCH  = 3'd0, OP_READ = 3'd1, OP_READ16 = 3'd2, OP_WRITE = 3'd3,
                          OP_PUSH   = 3'd4, OP_POP  = 3'd5, OP_VECTOR = 3'd6, OP_NOP   = 3'd7;

   state_t            state, nxt;
   logic [2:0]        op_q;
   logic              boot_q, bus_q, two_byte;
   logic [ADDR_W-1:0] cursor, pc_q, hi_addr;
   logic [7:0]        sp_q, out_q;
   logic [15:0]       rdata_q;

   function automatic logic [ADDR_W-1:0] stack_addr(input logic [7:0] s);
      return ADDR_W'({STACK_PAGE, s});
   endfunction

   assign two_byte = (op_q == OP_READ16) || (op_q == OP_VECTOR);

`ifdef NMOS_PAGE_WRAP_EN
   always_comb begin
      hi_addr = cursor + ADDR_W'(1);
      if (op_q == OP_READ16) hi_addr = {cursor[ADDR_W-1:8], cursor[7:0] + 8'd1};
   end
`else
   assign hi_addr = cursor + ADDR_W'(1);
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= BOOT;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         BOOT:       nxt = ADDR_LO;
         IDLE, DONE: begin
            nxt = IDLE;
            if (bif.req)
               nxt = (bif.op == OP_WRITE || bif.op == OP_PUSH || bif.op == OP_NOP) ? WRITE : ADDR_LO;
         end
         ADDR_LO:    nxt = DATA_LO;
         DATA_LO:    nxt = two_byte ? DATA_HI : DONE;
         DATA_HI:    nxt = boot_q ? IDLE : DONE;
         WRITE:      nxt = DONE;
         default:    nxt = IDLE;
      endcase
   end

   always_comb begin
      bif.busy    = !(state == IDLE || state == DONE);
      bif.done    = (state == DONE);
      bif.rd      = (state == ADDR_LO) || (state == DATA_LO && two_byte);
      bif.we      = (state == WRITE) && (op_q != OP_NOP);
      bif.address = bus_q ? cursor : pc_q;
   end

   assign bif.pc    = pc_q;
   assign bif.sp    = sp_q;
   assign bif.rdata = rdata_q;
   assign bif.out   = out_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q    <= '0;
         sp_q    <= SP_INIT;
         rdata_q <= '0;
         out_q   <= '0;
         op_q    <= OP_VECTOR;
         boot_q  <= 1'b1;
         bus_q   <= 1'b1;
         cursor  <= ADDR_W'(RESET_VECTOR);
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bif.pc_load) pc_q <= bif.pc_value;
               if (bif.req) begin
                  op_q   <= bif.op;
                  boot_q <= 1'b0;
                  bus_q  <= (bif.op != OP_FETCH);
                  cursor <= bif.addr_in;
                  case (bif.op)
                     OP_PUSH: begin
                        cursor <= stack_addr(sp_q);
                        sp_q   <= sp_q - 8'd1;
                        out_q  <= bif.wdata;
                     end
                     // pre-increment: POP reads the slot above the current SP
                     OP_POP: begin
                        cursor <= stack_addr(sp_q + 8'd1);
                        sp_q   <= sp_q + 8'd1;
                     end
                     OP_WRITE: out_q <= bif.wdata;
                     default: ;
                  endcase
               end
            end
            ADDR_LO: if (two_byte) cursor <= hi_addr;
            DATA_LO: begin
               rdata_q <= {8'h00, bif.data};
               if (op_q == OP_FETCH) pc_q <= pc_q + ADDR_W'(1);
            end
            DATA_HI: begin
               rdata_q[15:8] <= bif.data;
               if (op_q == OP_VECTOR) pc_q <= ADDR_W'({bif.data, rdata_q[7:0]});
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/nes6502_biu.md
Name: nes6502_biu

Overview:
Parametrised bus interface unit for the 6502 core. It owns PC and the stack pointer, and it multiplexes the single memory port between PC and an explicit address cursor. It runs multi-cycle memory operations for the execute unit: fetch, read, 16-bit read, write, push, pop and vector load. It also performs the reset-vector boot sequence. Memory is synchronous: data is valid the cycle after `address`/`rd` are driven.

Parameters:
ADDR_W, 16, width of address bus, PC and cursor
RESET_VECTOR, 16'hFFFC, address of low byte of reset vector (truncated to ADDR_W)
STACK_PAGE, 8'h01, high byte of stack addresses (zero-extended above bit 15 if ADDR_W>16)
SP_INIT, 8'hFD, stack pointer value after reset

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
req  in  1  operation request, sampled only when busy=0
op  in  3  0 FETCH, 1 READ, 2 READ16, 3 WRITE, 4 PUSH, 5 POP, 6 VECTOR, 7 NOP
addr_in  in  ADDR_W  cursor address for READ/READ16/WRITE/VECTOR
wdata  in  8  byte for WRITE/PUSH
pc_load  in  1  load PC from pc_value (only when busy=0)
pc_value  in  ADDR_W  new PC
busy  out  1  operation or boot in progress
done  out  1  one-cycle completion pulse
rdata  out  16  read result, low byte first; held until next accept
pc  out  ADDR_W  program counter
sp  out  8  stack pointer
address  out  ADDR_W  memory address (bus ? cursor : pc)
data  in  8  memory read data
out  out  8  memory write data
rd  out  1  read strobe
we  out  1  write strobe

Behaviour:
- Reset values: pc=0, sp=SP_INIT, rdata=0, out=0, rd=0, we=0, done=0, busy=1, bus select=cursor, cursor=RESET_VECTOR.
- Reset aborts any operation; rd/we are low in the cycle after reset is sampled.
- Boot: the first cycle after reset falls starts the internal VECTOR sequence at RESET_VECTOR. PC is loaded from {data@RV+1, data@RV}. busy falls in the cycle after the high byte is captured. No done pulse for boot.
- States: BOOT, IDLE, ADDR_LO, DATA_LO (issues hi addr for 16-bit ops), DATA_HI, WRITE, DONE.
- Accept: in cycle T, req=1 and busy=0 → busy=1 from T+1.
- FETCH/READ/POP: rd=1 in T+1; data captured at end of T+2 into rdata[7:0], rdata[15:8]=0; done=1 in T+3.
- READ16/VECTOR: lo addr in T+1, hi addr (+1) in T+2, done in T+4.
- WRITE/PUSH: we=1, out=wdata in T+1; done in T+2.
- NOP: no memory access; done in T+2.
- busy=0 in the done cycle, so a new req may be accepted there (back-to-back).
- FETCH uses address=pc, and pc+1 when done. All other ops use address=cursor.
- PUSH: address {STACK_PAGE,sp}, then sp-1. POP: sp+1 first, then reads {STACK_PAGE,sp+1}.
- VECTOR: pc<=rdata when done.
- Wrap-around: pc wraps modulo 2^ADDR_W. sp wraps modulo 256: PUSH at sp=00 writes 0x0100 and leaves sp=FF; POP at sp=FF reads 0x0100 and leaves sp=00. READ16 high-byte address is addr_in+1 modulo 2^ADDR_W.
- pc_load with busy=0 loads pc at that edge. If req is also 1 in that cycle, the op is accepted and FETCH uses the new pc. pc_load is ignored while busy.
- rd and we are never both high. out holds its last value when we=0.

Optional Feature:
NMOS_PAGE_WRAP_EN: when defined, the READ16 high-byte address is {addr_in[ADDR_W-1:8], addr_in[7:0]+1}, matching the NMOS JMP (ind) page bug. VECTOR and boot are unaffected. When undefined, the full-width +1 rule applies.

Test Plan:
- Boot: mem[FFFC]=00, mem[FFFD]=C0, release reset → pc=C000, sp=FD, busy falls, done never pulses.
- FETCH ×2 back-to-back from pc=C000, mem=A9,42 → rdata=00A9 then 0042, done pulses in T+3 and the second done cycle, pc=C002.
- PUSH 0x55 at sp=00, then POP → write to 0x0100 with we one cycle, sp=FF; POP returns rdata=0055, sp=00.
- READ16 addr_in=10FF, mem[10FF]=34, mem[1100]=12, mem[1000]=56 → rdata=1234 without macro, 5634 with NMOS_PAGE_WRAP_EN.
- pc_load=1, pc_value=8000 with req FETCH in same cycle → address=8000 in T+1, pc=8001 after done. pc_load during busy leaves pc unchanged.
- Assert reset in T+2 of a READ16 → rd=0 next cycle, no done, boot sequence reruns and pc is reloaded from the vector.
